present_sbox_layer_ctrl: RTL and testbench

//  Serial sequencer for the 3-share, 2nd-order PRESENT S-box (3-stage pipeline, no enable).

---
 rtl/present_sbox_layer_ctrl.sv | 264 ++++++++++++++++++++++++++
 tb/tb_present_sbox_layer_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/present_sbox_layer_ctrl.sv
// present_sbox_layer_ctrl
// Serial sequencer feeding the 16 nibbles of a 3-share 64-bit state through one
// shared, 3-stage, 2nd-order masked PRESENT S-box. Fresh randomness is delayed so
// that each slice lands on the S-box stage that consumes it. The recycled rs value
// is chained from one nibble to the next. Results are gathered into a shadow buffer
// and published to state_out* in one step when the run completes.
//
// Handshake: a PRNG word is consumed in every cycle where rnd_valid & rnd_ready
// are both high. rnd_ready is high for the whole FEED phase and low otherwise.
// Each consumed word is one nibble issue. A FEED cycle without rnd_valid issues
// a bubble, which carries zero data and zero randomness.
module present_sbox_layer_ctrl #(
    parameter int SBOX_LAT = 3,
    parameter int RF_DLY   = 1,
    parameter int RG_DLY   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    input  logic [63:0] state_in1,
    input  logic [63:0] state_in2,
    input  logic [63:0] state_in3,
    output logic [63:0] state_out1,
    output logic [63:0] state_out2,
    output logic [63:0] state_out3,
    input  logic        rnd_valid,
    output logic        rnd_ready,
    input  logic [52:0] rnd_data,
    output logic [3:0]  sbox_in1,
    output logic [3:0]  sbox_in2,
    output logic [3:0]  sbox_in3,
    output logic [44:0] sbox_r,
    output logic [7:0]  sbox_rs_in,
    input  logic [7:0]  sbox_rs_out,
    input  logic [3:0]  sbox_out1,
    input  logic [3:0]  sbox_out2,
    input  logic [3:0]  sbox_out3,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_busy;
    logic        r_done;
    logic        r_rnd_ready;
    logic [3:0]  r_issue_cnt;

    // Input snapshot taken on start, so later state_in* changes do not matter
    logic [63:0] r_sh1;
    logic [63:0] r_sh2;
    logic [63:0] r_sh3;

    // Result collection buffer and the published copy
    logic [63:0] r_buf1;
    logic [63:0] r_buf2;
    logic [63:0] r_buf3;
    logic [63:0] r_out1;
    logic [63:0] r_out2;
    logic [63:0] r_out3;

    // Per-slot bookkeeping that travels alongside the S-box pipeline.
    // Index 0 is the slot one cycle after issue.
    logic [SBOX_LAT-1:0] r_vld_pipe;
    logic [3:0]          r_tag_pipe [SBOX_LAT];
    logic [26:0]         r_rf_pipe  [RF_DLY];
    logic [7:0]          r_rs_pipe  [RF_DLY];
    logic [17:0]         r_rg_pipe  [RG_DLY];
    logic [7:0]          r_rs_hold;

    logic        w_issue;
    logic [5:0]  w_sel_idx;
    logic        w_tail_vld;
    logic [5:0]  w_tail_idx;
    logic        w_pipe_upstream_empty;
    logic        w_f_vld;
    logic [3:0]  w_f_tag;
    logic [63:0] w_buf1_nxt;
    logic [63:0] w_buf2_nxt;
    logic [63:0] w_buf3_nxt;

    // A nibble is issued in every FEED cycle that has a PRNG word available
    assign w_issue   = (r_state == ST_FEED) && rnd_valid;
    assign w_sel_idx = {r_issue_cnt, 2'b00};

    assign w_tail_vld = r_vld_pipe[SBOX_LAT-1];
    assign w_tail_idx = {r_tag_pipe[SBOX_LAT-1], 2'b00};

    // Only the tail slot is still in flight once every earlier slot is empty
    assign w_pipe_upstream_empty = (r_vld_pipe[SBOX_LAT-2:0] == '0);

    assign w_f_vld = r_vld_pipe[RF_DLY-1];
    assign w_f_tag = r_tag_pipe[RF_DLY-1];

    // Nibble shares for the issue cycle; zero on bubbles and outside FEED
    always_comb begin
        sbox_in1 = 4'h0;
        sbox_in2 = 4'h0;
        sbox_in3 = 4'h0;
        if (w_issue) begin
            sbox_in1 = r_sh1[w_sel_idx +: 4];
            sbox_in2 = r_sh2[w_sel_idx +: 4];
            sbox_in3 = r_sh3[w_sel_idx +: 4];
        end
    end

    // F-stage rs: the first nibble takes its own seed, later nibbles take the
    // rs_out left behind by the previous nibble
    always_comb begin
        sbox_rs_in = 8'h00;
        if (w_f_vld) begin
            if (w_f_tag == 4'd0) begin
                sbox_rs_in = r_rs_pipe[RF_DLY-1];
            end else begin
                sbox_rs_in = r_rs_hold;
            end
        end
    end

    assign sbox_r = {r_rg_pipe[RG_DLY-1], r_rf_pipe[RF_DLY-1]};

    // Merge the S-box result arriving at the pipe tail into the collection buffer
    always_comb begin
        w_buf1_nxt = r_buf1;
        w_buf2_nxt = r_buf2;
        w_buf3_nxt = r_buf3;
        if (w_tail_vld) begin
            w_buf1_nxt[w_tail_idx +: 4] = sbox_out1;
            w_buf2_nxt[w_tail_idx +: 4] = sbox_out2;
            w_buf3_nxt[w_tail_idx +: 4] = sbox_out3;
        end
    end

    // Run control: snapshot on start, count issues, drain, publish results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_rnd_ready <= 1'b0;
            r_issue_cnt <= 4'd0;
            r_sh1       <= 64'h0;
            r_sh2       <= 64'h0;
            r_sh3       <= 64'h0;
            r_out1      <= 64'h0;
            r_out2      <= 64'h0;
            r_out3      <= 64'h0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_sh1       <= state_in1;
                        r_sh2       <= state_in2;
                        r_sh3       <= state_in3;
                        r_issue_cnt <= 4'd0;
                        r_busy      <= 1'b1;
                        r_rnd_ready <= 1'b1;
                        r_state     <= ST_FEED;
                    end
                end
                ST_FEED: begin
                    if (rnd_valid) begin
                        if (r_issue_cnt == 4'd15) begin
                            r_rnd_ready <= 1'b0;
                            r_state     <= ST_DRAIN;
                        end else begin
                            r_issue_cnt <= r_issue_cnt + 4'd1;
                        end
                    end
                end
                ST_DRAIN: begin
                    // The last result is merged at this same edge, so publish the merged view
                    if (w_pipe_upstream_empty) begin
                        r_out1  <= w_buf1_nxt;
                        r_out2  <= w_buf2_nxt;
                        r_out3  <= w_buf3_nxt;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Slot pipeline: valid/tag plus stage-aligned randomness, zero on bubbles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_pipe <= '0;
            for (int i = 0; i < SBOX_LAT; i++) begin
                r_tag_pipe[i] <= 4'd0;
            end
            for (int i = 0; i < RF_DLY; i++) begin
                r_rf_pipe[i] <= 27'd0;
                r_rs_pipe[i] <= 8'd0;
            end
            for (int i = 0; i < RG_DLY; i++) begin
                r_rg_pipe[i] <= 18'd0;
            end
        end else begin
            r_vld_pipe    <= {r_vld_pipe[SBOX_LAT-2:0], w_issue};
            r_tag_pipe[0] <= w_issue ? r_issue_cnt : 4'd0;
            for (int i = 1; i < SBOX_LAT; i++) begin
                r_tag_pipe[i] <= r_tag_pipe[i-1];
            end
            r_rf_pipe[0] <= w_issue ? rnd_data[26:0]  : 27'd0;
            r_rs_pipe[0] <= w_issue ? rnd_data[52:45] : 8'd0;
            for (int i = 1; i < RF_DLY; i++) begin
                r_rf_pipe[i] <= r_rf_pipe[i-1];
                r_rs_pipe[i] <= r_rs_pipe[i-1];
            end
            r_rg_pipe[0] <= w_issue ? rnd_data[44:27] : 18'd0;
            for (int i = 1; i < RG_DLY; i++) begin
                r_rg_pipe[i] <= r_rg_pipe[i-1];
            end
        end
    end

    // Remember the rs_out of the nibble now in the F stage for the next nibble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rs_hold <= 8'd0;
        end else if (w_f_vld) begin
            r_rs_hold <= sbox_rs_out;
        end
    end

    // Collection buffer follows the merged view every cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf1 <= 64'h0;
            r_buf2 <= 64'h0;
            r_buf3 <= 64'h0;
        end else begin
            r_buf1 <= w_buf1_nxt;
            r_buf2 <= w_buf2_nxt;
            r_buf3 <= w_buf3_nxt;
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign rnd_ready  = r_rnd_ready;
    assign state_out1 = r_out1;
    assign state_out2 = r_out2;
    assign state_out3 = r_out3;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_present_sbox_layer_ctrl.sv
// Bench for present_sbox_layer_ctrl: a behavioural masked S-box stands in for the
// real instance, and a cycle-level reference derived from the issue/latency rules
// predicts handshake, alignment, rs chaining and the unmasked result.
module tb_present_sbox_layer_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        busy, done;
    logic [63:0] state_in1 = '0, state_in2 = '0, state_in3 = '0;
    logic [63:0] state_out1, state_out2, state_out3;
    logic        rnd_valid = 1'b0;
    logic        rnd_ready;
    logic [52:0] rnd_data = '0;
    logic [3:0]  sbox_in1, sbox_in2, sbox_in3;
    logic [44:0] sbox_r;
    logic [7:0]  sbox_rs_in, sbox_rs_out;
    logic [3:0]  sbox_out1, sbox_out2, sbox_out3;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] prev_res = 64'h0;

    present_sbox_layer_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .state_in1(state_in1), .state_in2(state_in2), .state_in3(state_in3),
        .state_out1(state_out1), .state_out2(state_out2), .state_out3(state_out3),
        .rnd_valid(rnd_valid), .rnd_ready(rnd_ready), .rnd_data(rnd_data),
        .sbox_in1(sbox_in1), .sbox_in2(sbox_in2), .sbox_in3(sbox_in3),
        .sbox_r(sbox_r), .sbox_rs_in(sbox_rs_in), .sbox_rs_out(sbox_rs_out),
        .sbox_out1(sbox_out1), .sbox_out2(sbox_out2), .sbox_out3(sbox_out3),
        .dbg_state(dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    function automatic logic [3:0] sbox4(input logic [3:0] x);
        case (x)
            4'h0: return 4'hC; 4'h1: return 4'h5; 4'h2: return 4'h6; 4'h3: return 4'hB;
            4'h4: return 4'h9; 4'h5: return 4'h0; 4'h6: return 4'hA; 4'h7: return 4'hD;
            4'h8: return 4'h3; 4'h9: return 4'hE; 4'hA: return 4'hF; 4'hB: return 4'h8;
            4'hC: return 4'h4; 4'hD: return 4'h7; 4'hE: return 4'h1; default: return 4'h2;
        endcase
    endfunction

    function automatic logic [63:0] sbox_layer(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 16; i++) y[4*i +: 4] = sbox4(x[4*i +: 4]);
        return y;
    endfunction

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    // Behavioural 3-stage masked S-box: F stage takes r[3:0]^rs_in[3:0] as a mask,
    // G stage takes r[30:27]; output shares XOR to S(x) with those masks applied.
    logic [3:0] m_x1 = '0, m_x2 = '0, m_x3 = '0;
    logic [3:0] m_a2 = '0, m_a3 = '0, m_b3 = '0;
    always @(posedge clk) begin
        m_x1 <= sbox_in1 ^ sbox_in2 ^ sbox_in3;
        m_x2 <= m_x1;
        m_a2 <= sbox_r[3:0] ^ sbox_rs_in[3:0];
        m_x3 <= m_x2;
        m_a3 <= m_a2;
        m_b3 <= sbox_r[30:27];
    end
    assign sbox_out1   = sbox4(m_x3) ^ m_a3 ^ m_b3;
    assign sbox_out2   = m_a3;
    assign sbox_out3   = m_b3;
    assign sbox_rs_out = {sbox_rs_in[6:0], sbox_rs_in[7]} ^ sbox_r[7:0] ^ 8'h5A;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'h0);
        chk({tag, "_done"}, 64'(done), 64'h0);
        chk({tag, "_rnd_ready"}, 64'(rnd_ready), 64'h0);
        chk({tag, "_sbox_in"}, 64'({sbox_in1, sbox_in2, sbox_in3}), 64'h0);
        chk({tag, "_sbox_r"}, 64'(sbox_r), 64'h0);
        chk({tag, "_rs_in"}, 64'(sbox_rs_in), 64'h0);
        chk({tag, "_out1"}, state_out1, 64'h0);
        chk({tag, "_out2"}, state_out2, 64'h0);
        chk({tag, "_out3"}, state_out3, 64'h0);
    endtask

    // One run from start to the cycle after done. mode: 0 valid always, 1 valid on
    // even cycles, 2 random valid. exp_done <= 0 means the done cycle is left to the
    // model alone. rst_cyc > 0 aborts the run with reset in that cycle.
    task automatic run_case(input logic [63:0] plain, input bit split, input int mode,
                            input int exp_done, input logic [63:0] exp_res,
                            input bit inject, input int rst_cyc);
        logic [63:0] s1, s2, s3, tmp;
        logic [52:0] rnd_at [80];
        bit          iss_at [80];
        int          nib_at [80];
        logic [7:0]  rs_seen [16];
        logic [7:0]  exp_rs;
        int nis, model_done, k;
        bit v, iss, exp_rdy, finished;
        for (int i = 0; i < 80; i++) begin
            iss_at[i] = 1'b0; nib_at[i] = 0; rnd_at[i] = '0;
        end
        for (int i = 0; i < 16; i++) rs_seen[i] = '0;
        nis = 0; model_done = 1000; finished = 1'b0;
        s1 = split ? rand64() : 64'h0;
        s2 = split ? rand64() : 64'h0;
        s3 = plain ^ s1 ^ s2;
        // cycle 0: start
        @(posedge clk); #1;
        start = 1'b1; state_in1 = s1; state_in2 = s2; state_in3 = s3;
        rnd_valid = 1'b1; tmp = rand64(); rnd_data = tmp[52:0];
        for (int c = 1; c < 80; c++) begin
            @(posedge clk); #1;
            start = (inject && (c == 5 || c == 12 || c == model_done)) ? 1'b1 : 1'b0;
            state_in1 = rand64(); state_in2 = rand64(); state_in3 = rand64();
            case (mode)
                0: v = 1'b1;
                1: v = (c % 2 == 0);
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            rnd_valid = v;
            tmp = rand64(); rnd_data = tmp[52:0];
            if (c == rst_cyc) begin
                rst_n = 1'b0;
                #1;
                chk_all_zero("midrun_reset");
                for (int j = 0; j < 4; j++) begin
                    @(posedge clk); #1;
                    start = 1'b0; rnd_valid = 1'b0;
                    if (j == 1) rst_n = 1'b1;
                    @(negedge clk);
                    chk("post_reset_no_done", 64'(done), 64'h0);
                    chk("post_reset_idle", 64'(busy), 64'h0);
                end
                prev_res = 64'h0;
                return;
            end
            @(negedge clk);
            exp_rdy = (nis < 16);
            iss = exp_rdy && v;
            chk("rnd_ready", 64'(rnd_ready), 64'(exp_rdy));
            chk("sbox_in1", 64'(sbox_in1), iss ? 64'(s1[4*nis +: 4]) : 64'h0);
            chk("sbox_in2", 64'(sbox_in2), iss ? 64'(s2[4*nis +: 4]) : 64'h0);
            chk("sbox_in3", 64'(sbox_in3), iss ? 64'(s3[4*nis +: 4]) : 64'h0);
            iss_at[c] = iss; rnd_at[c] = rnd_data; nib_at[c] = nis;
            // F-stage randomness and rs chaining
            chk("sbox_r_f", 64'(sbox_r[26:0]), iss_at[c-1] ? 64'(rnd_at[c-1][26:0]) : 64'h0);
            if (iss_at[c-1]) begin
                k = nib_at[c-1];
                exp_rs = (k == 0) ? rnd_at[c-1][52:45] : rs_seen[k-1];
                rs_seen[k] = sbox_rs_out;
            end else begin
                exp_rs = 8'h00;
            end
            chk("sbox_rs_in", 64'(sbox_rs_in), 64'(exp_rs));
            // G-stage randomness
            if (c >= 2)
                chk("sbox_r_g", 64'(sbox_r[44:27]), iss_at[c-2] ? 64'(rnd_at[c-2][44:27]) : 64'h0);
            if (iss) begin
                nis++;
                if (nis == 16) model_done = c + 4;
            end
            chk("done", 64'(done), 64'(c == model_done));
            chk("busy", 64'(busy), 64'(c <= model_done));
            if (c < model_done)
                chk("out_stable", state_out1 ^ state_out2 ^ state_out3, prev_res);
            if (c == model_done) begin
                chk("result", state_out1 ^ state_out2 ^ state_out3, exp_res);
                if (exp_done > 0) chk("done_cycle", 64'(c), 64'(exp_done));
                prev_res = exp_res;
            end
            if (c == model_done + 1) begin
                finished = 1'b1;
                break;
            end
        end
        start = 1'b0;
        rnd_valid = 1'b0;
        if (!finished) chk("done_timeout", 64'h0, 64'h1);
    endtask

    typedef struct {
        logic [63:0] plain;
        bit          split;
        int          mode;
        int          exp_done;
        logic [63:0] exp_res;
    } vec_t;

    vec_t vecs [8];
    logic [63:0] rp;

    initial begin
        // vector table
        vecs[0] = '{64'h0, 1'b0, 0, 20, 64'hCCCC_CCCC_CCCC_CCCC};
        vecs[1] = '{64'h0123_4567_89AB_CDEF, 1'b1, 0, 20, 64'hC56B_90AD_3EF8_4712};
        vecs[2] = '{64'h0123_4567_89AB_CDEF, 1'b1, 1, 36, 64'hC56B_90AD_3EF8_4712};
        for (int i = 3; i < 8; i++) begin
            rp = rand64();
            vecs[i] = '{rp, 1'b1, (i == 7) ? 0 : 2, (i == 7) ? 20 : 0, sbox_layer(rp)};
        end

        // reset state
        #2;
        chk_all_zero("reset");
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++)
            run_case(vecs[i].plain, vecs[i].split, vecs[i].mode, vecs[i].exp_done,
                     vecs[i].exp_res, 1'b0, -1);

        // start pulses while busy and in the done cycle are ignored
        run_case(64'h0123_4567_89AB_CDEF, 1'b1, 0, 20, 64'hC56B_90AD_3EF8_4712, 1'b1, -1);
        run_case(64'hFEDC_BA98_7654_3210, 1'b1, 2, 0, sbox_layer(64'hFEDC_BA98_7654_3210), 1'b1, -1);

        // reset in cycle 9 aborts, then a fresh run completes
        run_case(rand64(), 1'b1, 0, 20, 64'h0, 1'b0, 9);
        run_case(64'h0123_4567_89AB_CDEF, 1'b1, 1, 36, 64'hC56B_90AD_3EF8_4712, 1'b0, -1);
        rp = rand64();
        run_case(rp, 1'b1, 2, 0, sbox_layer(rp), 1'b0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
